prpg_seq_ctrl: RTL and testbench

Sequencer for the 10-bit pseudo-random pattern generator (Prpg10). It accepts run commands (seed + run length) over a valid/ready handshake and drives the generator's load and start controls with exact cycle counts. It reports completion with a status code, the number of cycles run, and an optional signature compacted from the generator output. It sits between the test/control logic and the Prpg10 instance, and it is the only driver of PrpgUpld, PrpgStart and PrpgSeed.

---
 rtl/prpg_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_prpg_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prpg_seq_ctrl.sv
// Run sequencer for the Prpg10 pattern generator: seed load, settle, timed run and completion status.
// Define PRPG_CTRL_SIG_EN to compact PrpgOut into Signature during RUN; otherwise Signature is 0.
module prpg_seq_ctrl #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [WIDTH-1:0] CmdSeed,
  input  logic [LEN_W-1:0] CmdLen,
  input  logic             Abort,
  output logic [WIDTH-1:0] PrpgSeed,
  output logic             PrpgUpld,
  output logic             PrpgStart,
  input  logic [WIDTH-1:0] PrpgOut,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       DoneStatus,
  output logic [LEN_W-1:0] RunCnt,
  output logic [WIDTH-1:0] Signature
);

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StRun, StDone} state_e;

  localparam logic [3:0]       SettleInit = 4'(SETTLE_CYC - 1);
  localparam logic [1:0]       StatOk     = 2'b00;
  localparam logic [1:0]       StatAbort  = 2'b01;
  localparam logic [1:0]       StatBadSd  = 2'b10;
  localparam logic [LEN_W-1:0] LenOne     = LEN_W'(1);

  state_e           state;
  logic [LEN_W-1:0] len_left;
  logic [3:0]       settle_cnt;

  assign CmdReady = (state == StIdle);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= StIdle;
      len_left   <= '0;
      settle_cnt <= '0;
      PrpgSeed   <= '0;
      PrpgUpld   <= 1'b0;
      PrpgStart  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      DoneStatus <= StatOk;
      RunCnt     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (CmdValid) begin
            PrpgSeed <= CmdSeed;
            len_left <= CmdLen;
            RunCnt   <= '0;
            // An all-zero seed would lock the LFSR up, so it is rejected without a load.
            if (CmdSeed == '0) begin
              state      <= StDone;
              Done       <= 1'b1;
              DoneStatus <= StatBadSd;
            end else begin
              state      <= StLoad;
              PrpgUpld   <= 1'b1;
              Busy       <= 1'b1;
              DoneStatus <= StatOk;
            end
          end
        end
        StLoad: begin
          PrpgUpld <= 1'b0;
          if (Abort) begin
            state      <= StDone;
            Busy       <= 1'b0;
            Done       <= 1'b1;
            DoneStatus <= StatAbort;
          end else begin
            state      <= StSettle;
            settle_cnt <= SettleInit;
          end
        end
        StSettle: begin
          if (Abort) begin
            state      <= StDone;
            Busy       <= 1'b0;
            Done       <= 1'b1;
            DoneStatus <= StatAbort;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else if (len_left == '0) begin
            state      <= StDone;
            Busy       <= 1'b0;
            Done       <= 1'b1;
            DoneStatus <= StatOk;
          end else begin
            state     <= StRun;
            PrpgStart <= 1'b1;
          end
        end
        StRun: begin
          // The cycle ending on an abort edge still ran, so it is counted.
          RunCnt   <= RunCnt + LenOne;
          len_left <= len_left - LenOne;
          if (Abort || (len_left == LenOne)) begin
            state      <= StDone;
            PrpgStart  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b1;
            DoneStatus <= Abort ? StatAbort : StatOk;
          end
        end
        StDone: begin
          state <= StIdle;
          Done  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef PRPG_CTRL_SIG_EN
  logic [WIDTH-1:0] sig;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sig <= '0;
    end else if ((state == StIdle) && CmdValid && (CmdSeed != '0)) begin
      sig <= '0;
    end else if ((state == StRun) && !Abort) begin
      sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ PrpgOut;
    end
  end

  assign Signature = sig;
`else
  logic unused_prpg_out;

  assign unused_prpg_out = ^PrpgOut;
  assign Signature       = '0;
`endif

endmodule

// File: tb/tb_prpg_seq_ctrl.sv
// Bench for prpg_seq_ctrl: behavioural Prpg10, a transaction-timeline model checked every cycle,
// directed scenarios with literal expectations and a randomized command stream.
module tb_prpg_seq_ctrl;

  localparam int W  = 10;
  localparam int LW = 16;
  localparam int S  = 1;

  logic          Clk      = 1'b0;
  logic          Reset    = 1'b1;
  logic          CmdValid = 1'b0;
  logic          Abort    = 1'b0;
  logic [W-1:0]  CmdSeed  = '0;
  logic [LW-1:0] CmdLen   = '0;
  logic [W-1:0]  gen      = '0;
  logic          CmdReady, PrpgUpld, PrpgStart, Busy, Done;
  logic [W-1:0]  PrpgSeed, Signature;
  logic [1:0]    DoneStatus;
  logic [LW-1:0] RunCnt;

  always #5 Clk = ~Clk;

  prpg_seq_ctrl #(.WIDTH(W), .LEN_W(LW), .SETTLE_CYC(S)) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdSeed(CmdSeed),
    .CmdLen(CmdLen), .Abort(Abort), .PrpgSeed(PrpgSeed), .PrpgUpld(PrpgUpld),
    .PrpgStart(PrpgStart), .PrpgOut(gen), .Busy(Busy), .Done(Done), .DoneStatus(DoneStatus),
    .RunCnt(RunCnt), .Signature(Signature)
  );

  // Prpg10: x^10 + x^7 + 1, maximal length 1023
  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  always @(posedge Clk) begin
    if (PrpgUpld) gen <= PrpgSeed;
    else if (PrpgStart) gen <= lfsr_next(gen);
  end

  // Model: each command is a timeline (accept interval a, done interval done_c); outputs follow
  // from where the current interval lies on it.
  int         cyc = 0, acc_cyc = -1, a = 0, done_c = 0;
  bit         txn = 1'b0, bad = 1'b0;
  logic [1:0] stat = 2'b00;
  logic [W-1:0] seed_m = '0, sig_m = '0;

  int vectors = 0, miscompares = 0;
  int upld_n = 0, start_n = 0, done_n = 0, first_start = -1, done_at = -1;
  bit prev_start = 1'b0;
  logic [1:0]    done_st = '0;
  logic [LW-1:0] done_rc = '0;
  logic [W-1:0]  done_sig = '0;

  function automatic bit in_txn(input int c);
    return txn && (c >= a) && (c <= done_c);
  endfunction

  task automatic model_edge();
    int p;
    p = cyc;
    if (Reset) begin
      txn = 1'b0; stat = 2'b00; seed_m = '0; sig_m = '0;
    end else begin
      cyc++;
      if (!in_txn(p) && CmdValid) begin
        txn = 1'b1; a = cyc; acc_cyc = cyc; seed_m = CmdSeed; bad = (CmdSeed == '0);
        if (bad) begin
          done_c = cyc; stat = 2'b10;
        end else begin
          done_c = cyc + 1 + S + int'(CmdLen); stat = 2'b00; sig_m = '0;
        end
      end else if (txn && !bad && p >= a && p < done_c) begin
`ifdef PRPG_CTRL_SIG_EN
        if (p >= a + 1 + S && !Abort) sig_m = {sig_m[W-2:0], sig_m[W-1]} ^ gen;
`endif
        if (Abort) begin
          done_c = cyc; stat = 2'b01;
        end
      end
    end
  endtask

  task automatic compare_cycle();
    int c, rc, hi;
    bit it, good;
    logic [42:0] exp_v, act_v;
    c = cyc; it = in_txn(c); good = it && !bad; rc = 0;
    if (txn && !bad) begin
      hi = (c < done_c) ? c : done_c;
      rc = hi - (a + 1 + S);
      if (rc < 0) rc = 0;
    end
    exp_v = {!it, good && c == a, good && c >= a + 1 + S && c < done_c, good && c < done_c,
             it && c == done_c, stat, LW'(rc), seed_m, sig_m};
    act_v = {CmdReady, PrpgUpld, PrpgStart, Busy, Done, DoneStatus, RunCnt, PrpgSeed, Signature};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle %0d outputs: got %h expected %h (ready,upld,start,busy,done,stat,cnt,seed,sig)",
               c, act_v, exp_v);
    end
    if (PrpgUpld) upld_n++;
    if (PrpgStart) begin
      start_n++;
      if (!prev_start) first_start = c;
    end
    prev_start = PrpgStart;
    if (Done) begin
      done_n++; done_at = c; done_st = DoneStatus; done_rc = RunCnt; done_sig = Signature;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    if (!Reset) compare_cycle();
    else prev_start = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] s, input logic [LW-1:0] l, input bit ab_same);
    bit ok;
    ok = 1'b0;
    CmdSeed = s; CmdLen = l; CmdValid = 1'b1; Abort = ab_same;
    for (int i = 0; i < 200; i++) begin
      step();
      Abort = 1'b0;
      if (acc_cyc == cyc) begin
        ok = 1'b1;
        break;
      end
    end
    CmdValid = 1'b0;
    chk("command accepted", int'(ok), 1);
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 5000 && done_n == n0; i++) step();
    chk("done seen before timeout", int'(done_n > n0), 1);
  endtask

  int n0, u0, s0;
  logic [W-1:0] g, sg;

  initial begin
    step(); step();
    chk("reset CmdReady", int'(CmdReady), 1);
    chk("reset Busy", int'(Busy), 0);
    chk("reset RunCnt", int'(RunCnt), 0);
    Reset = 1'b0;
    step(); step();

    // Full-period run from seed 1
    n0 = done_n; u0 = upld_n; s0 = start_n;
    send(10'h001, 16'd1023, 1'b0);
    wait_done(n0);
    chk("full run upld cycles", upld_n - u0, 1);
    chk("full run start cycles", start_n - s0, 1023);
    chk("full run start offset", first_start - acc_cyc, 2);
    chk("full run done offset", done_at - acc_cyc, 1025);
    chk("full run status", int'(done_st), 0);
    chk("full run RunCnt", int'(done_rc), 1023);
    chk("lfsr back at seed", int'(gen), 1);
    step();

    // Bad seed
    n0 = done_n; u0 = upld_n; s0 = start_n;
    send(10'h000, 16'd7, 1'b0);
    wait_done(n0);
    chk("bad seed done offset", done_at - acc_cyc, 0);
    chk("bad seed status", int'(done_st), 2);
    chk("bad seed upld", upld_n - u0, 0);
    chk("bad seed start", start_n - s0, 0);
    step();
    chk("ready after done", int'(CmdReady), 1);

    // Zero length
    n0 = done_n; u0 = upld_n; s0 = start_n;
    send(10'h155, 16'd0, 1'b0);
    wait_done(n0);
    chk("len0 upld", upld_n - u0, 1);
    chk("len0 start", start_n - s0, 0);
    chk("len0 done offset", done_at - acc_cyc, 2);
    chk("len0 status", int'(done_st), 0);
    chk("len0 RunCnt", int'(done_rc), 0);
    step();

    // Abort in RUN cycle 40, then an immediate second command
    n0 = done_n; s0 = start_n;
    send(10'h001, 16'd100, 1'b0);
    for (int i = 0; i < 500 && start_n - s0 < 40; i++) step();
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("start low after abort", int'(PrpgStart), 0);
    chk("abort done seen", int'(done_n > n0), 1);
    chk("abort status", int'(done_st), 1);
    chk("abort RunCnt", int'(done_rc), 40);
    n0 = done_n;
    send(10'h3FF, 16'd3, 1'b0);
    chk("second accept offset", acc_cyc - done_at, 2);
    wait_done(n0);
    chk("second status", int'(done_st), 0);
    step();

    // Reset in RUN cycle 10
    s0 = start_n;
    send(10'h001, 16'd100, 1'b0);
    for (int i = 0; i < 500 && start_n - s0 < 10; i++) step();
    #2 Reset = 1'b1;
    #1;
    chk("mid reset CmdReady", int'(CmdReady), 1);
    chk("mid reset PrpgUpld", int'(PrpgUpld), 0);
    chk("mid reset PrpgStart", int'(PrpgStart), 0);
    chk("mid reset PrpgSeed", int'(PrpgSeed), 0);
    chk("mid reset Busy", int'(Busy), 0);
    chk("mid reset Done", int'(Done), 0);
    chk("mid reset DoneStatus", int'(DoneStatus), 0);
    chk("mid reset RunCnt", int'(RunCnt), 0);
    chk("mid reset Signature", int'(Signature), 0);
    step();
    Reset = 1'b0;
    step();
    n0 = done_n; s0 = start_n;
    send(10'h2AA, 16'd5, 1'b0);
    wait_done(n0);
    chk("post reset status", int'(done_st), 0);
    chk("post reset RunCnt", int'(done_rc), 5);
    chk("post reset start", start_n - s0, 5);
    step();

    // Abort coinciding with acceptance is ignored
    n0 = done_n;
    send(10'h0F0, 16'd4, 1'b1);
    wait_done(n0);
    chk("abort at accept status", int'(done_st), 0);
    chk("abort at accept RunCnt", int'(done_rc), 4);
    step();

    // Signature over 16 samples from seed 1
    n0 = done_n;
    send(10'h001, 16'd16, 1'b0);
    wait_done(n0);
    g = 10'h001; sg = '0;
    for (int i = 0; i < 16; i++) begin
      sg = {sg[W-2:0], sg[W-1]} ^ g;
      g = lfsr_next(g);
    end
`ifdef PRPG_CTRL_SIG_EN
    chk("signature len16", int'(done_sig), int'(sg));
`else
    chk("signature stays 0", int'(done_sig), 0);
`endif
    step();

    // Random commands with stray aborts
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0]  rs;
      logic [LW-1:0] rl;
      int k;
      rs = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 1023));
      rl = LW'($urandom_range(0, 40));
      n0 = done_n;
      send(rs, rl, 1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, int'(rl) + 4);
        for (int i = 0; i < k; i++) step();
        Abort = 1'b1;
        step();
        Abort = 1'b0;
      end
      wait_done(n0);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        Abort = 1'($urandom_range(0, 1));
        step();
      end
      Abort = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
